// File: rtl/pupil_window_ctrl.sv
// Per-frame pupil tracker: accumulates dark-pixel coordinates, divides at frame end
// to find the centroid, and publishes a clamped marker box around it.
module pupil_window_ctrl #(
    parameter int CW      = 13,
    parameter int DW      = 10,
    parameter int H_MAX   = 1279,
    parameter int V_MAX   = 959,
    parameter int HALF    = 20,
    parameter int MIN_PIX = 64,
    parameter int NW      = 21,
    parameter int SW      = 34
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iEN,
    input  logic          iDVAL,
    input  logic [CW-1:0] iH_Cont,
    input  logic [CW-1:0] iV_Cont,
    input  logic [DW-1:0] iGray,
    input  logic [DW-1:0] iThresh,
    output logic [CW-1:0] oBOX_X0,
    output logic [CW-1:0] oBOX_X1,
    output logic [CW-1:0] oBOX_Y0,
    output logic [CW-1:0] oBOX_Y1,
    output logic          oFOUND,
    output logic          oUPD,
    output logic          oBUSY
);

    localparam int STW = $clog2(SW);

    typedef enum logic [1:0] {S_IDLE, S_DIV_X, S_DIV_Y, S_UPD} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  v_prev_q;
    logic [NW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  sx_q, sx_d, sy_q, sy_d;
    logic [NW-1:0]  div_q, div_d;
    logic [SW-1:0]  dvd_q, dvd_d;
    logic [SW-1:0]  sy_snap_q, sy_snap_d;
    logic [NW:0]    rem_q, rem_d;
    logic [STW-1:0] step_q, step_d;
    logic [CW-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic [CW-1:0]  x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic           found_q, found_d, upd_q, upd_d;

    logic           frame_end, dark, cnt_sat, q_bit;
    logic [NW:0]    rem_sh, rem_next;
    logic [SW-1:0]  dvd_step;

    function automatic logic [CW-1:0] lo_clamp(input logic [CW-1:0] c);
        return (c < CW'(HALF)) ? '0 : c - CW'(HALF);
    endfunction

    function automatic logic [CW-1:0] hi_clamp(input logic [CW-1:0] c, input logic [CW:0] lim);
        logic [CW:0] s;
        s = {1'b0, c} + (CW+1)'(HALF);
        return (s > lim) ? lim[CW-1:0] : s[CW-1:0];
    endfunction

    assign frame_end = (iV_Cont < v_prev_q);
    assign dark      = iDVAL & iEN & (iGray < iThresh);
    assign cnt_sat   = &cnt_q;

    // One restoring-division step: the quotient bit shifts in where the dividend bit left.
    assign rem_sh   = {rem_q[NW-1:0], dvd_q[SW-1]};
    assign q_bit    = (rem_sh >= {1'b0, div_q});
    assign rem_next = q_bit ? rem_sh - {1'b0, div_q} : rem_sh;
    assign dvd_step = {dvd_q[SW-2:0], q_bit};

    always_comb begin
        // NOTE: every next-state value defaults to its register first, so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        div_d     = div_q;
        dvd_d     = dvd_q;
        sy_snap_d = sy_snap_q;
        rem_d     = rem_q;
        step_d    = step_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        found_d   = found_q;
        upd_d     = 1'b0;

        if (!iEN) begin
            cnt_d = '0;
            sx_d  = '0;
            sy_d  = '0;
        end else if (frame_end) begin
            cnt_d = dark ? NW'(1) : '0;
            sx_d  = dark ? SW'(iH_Cont) : '0;
            sy_d  = dark ? SW'(iV_Cont) : '0;
        end else if (dark && !cnt_sat) begin
            cnt_d = cnt_q + 1'b1;
            sx_d  = sx_q + SW'(iH_Cont);
            sy_d  = sy_q + SW'(iV_Cont);
        end

        case (state_q)
            S_DIV_X, S_DIV_Y: begin
                dvd_d  = dvd_step;
                rem_d  = rem_next;
                step_d = step_q + 1'b1;
                if (step_q == STW'(SW-1)) begin
                    rem_d  = '0;
                    step_d = '0;
                    if (state_q == S_DIV_X) begin
                        cx_d    = dvd_step[CW-1:0];
                        dvd_d   = sy_snap_q;
                        state_d = S_DIV_Y;
                    end else begin
                        cy_d    = dvd_step[CW-1:0];
                        state_d = S_UPD;
                    end
                end
            end
            S_UPD: begin
                upd_d   = 1'b1;
                found_d = (div_q >= NW'(MIN_PIX));
                if (div_q >= NW'(MIN_PIX)) begin
                    x0_d = lo_clamp(cx_q);
                    x1_d = hi_clamp(cx_q, (CW+1)'(H_MAX));
                    y0_d = lo_clamp(cy_q);
                    y1_d = hi_clamp(cy_q, (CW+1)'(V_MAX));
                end
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // A new frame end always wins: re-snapshot and restart, dropping any divide in flight.
        if (frame_end) begin
            div_d     = cnt_q;
            dvd_d     = sx_q;
            sy_snap_d = sy_q;
            rem_d     = '0;
            step_d    = '0;
            state_d   = (cnt_q < NW'(MIN_PIX)) ? S_UPD : S_DIV_X;
        end
    end

    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (iRST) begin
            state_q   <= S_IDLE;
            v_prev_q  <= '0;
            cnt_q     <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            div_q     <= '0;
            dvd_q     <= '0;
            sy_snap_q <= '0;
            rem_q     <= '0;
            step_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y0_q      <= '0;
            y1_q      <= '0;
            found_q   <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_prev_q  <= iV_Cont;
            cnt_q     <= cnt_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            div_q     <= div_d;
            dvd_q     <= dvd_d;
            sy_snap_q <= sy_snap_d;
            rem_q     <= rem_d;
            step_q    <= step_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y0_q      <= y0_d;
            y1_q      <= y1_d;
            found_q   <= found_d;
            upd_q     <= upd_d;
        end
    end

    assign oBOX_X0 = x0_q;
    assign oBOX_X1 = x1_q;
    assign oBOX_Y0 = y0_q;
    assign oBOX_Y1 = y1_q;
    assign oFOUND  = found_q;
    assign oUPD    = upd_q;
    assign oBUSY   = (state_q == S_DIV_X) || (state_q == S_DIV_Y);

endmodule

// File: tb/tb_pupil_window_ctrl.sv
// Scoreboard bench for pupil_window_ctrl: a frame-level centroid model predicts each
// oUPD (time, oFOUND, box); a negedge monitor pops and compares.
module tb_pupil_window_ctrl;

    localparam int CW = 13, DW = 10, H_MAX = 1279, V_MAX = 959;
    localparam int HALF = 20, MIN_PIX = 64, SW = 34;

    logic          clk = 1'b0;
    logic          iRST = 1'b1, iEN = 1'b1, iDVAL = 1'b0;
    logic [CW-1:0] iH_Cont = '0, iV_Cont = '0;
    logic [DW-1:0] iGray = '0, iThresh = '0;
    logic [CW-1:0] oBOX_X0, oBOX_X1, oBOX_Y0, oBOX_Y1;
    logic          oFOUND, oUPD, oBUSY;

    always #5 clk = ~clk;

    pupil_window_ctrl dut (
        .iCLK(clk), .iRST(iRST), .iEN(iEN), .iDVAL(iDVAL),
        .iH_Cont(iH_Cont), .iV_Cont(iV_Cont), .iGray(iGray), .iThresh(iThresh),
        .oBOX_X0(oBOX_X0), .oBOX_X1(oBOX_X1), .oBOX_Y0(oBOX_Y0), .oBOX_Y1(oBOX_Y1),
        .oFOUND(oFOUND), .oUPD(oUPD), .oBUSY(oBUSY)
    );

    typedef struct {
        bit     found;
        int     cx;
        int     cy;
        longint exp_edge;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    int     checks = 0, errors = 0;
    longint edge_cnt = 0;

    // model state
    bit     en_m = 1'b1;
    int     thresh_m = 100;
    int     m_cnt = 0, m_prev_v = 0, cur_v = 0;
    longint m_sx = 0, m_sy = 0;
    int     hold_x0 = 0, hold_x1 = 0, hold_y0 = 0, hold_y1 = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int lo_box(input int c);
        return (c < HALF) ? 0 : c - HALF;
    endfunction

    function automatic int hi_box(input int c, input int lim);
        return (c + HALF > lim) ? lim : c + HALF;
    endfunction

    // Frame closed at edge n: a newer frame end before the pending update lands replaces it.
    task automatic finalize(input longint n);
        exp_t e;
        if (sb_q.size() > 0 && sb_q[$].exp_edge > n) void'(sb_q.pop_back());
        e.found = (m_cnt >= MIN_PIX);
        e.cx = e.found ? int'(m_sx / m_cnt) : 0;
        e.cy = e.found ? int'(m_sy / m_cnt) : 0;
        e.exp_edge = e.found ? n + 2 * SW + 1 : n + 1;
        sb_q.push_back(e);
    endtask

    task automatic pix(input int h, input int v, input int g, input bit dv);
        longint n;
        bit fe, dk;
        @(posedge clk);
        #1;
        iH_Cont = CW'(h);
        iV_Cont = CW'(v);
        iGray   = DW'(g);
        iDVAL   = dv;
        iEN     = en_m;
        iThresh = DW'(thresh_m);
        n  = edge_cnt + 1;
        fe = (v < m_prev_v);
        dk = dv && en_m && (g < thresh_m);
        if (fe) finalize(n);
        if (!en_m) begin
            m_cnt = 0; m_sx = 0; m_sy = 0;
        end else if (fe) begin
            m_cnt = dk ? 1 : 0; m_sx = dk ? h : 0; m_sy = dk ? v : 0;
        end else if (dk) begin
            m_cnt++; m_sx += h; m_sy += v;
        end
        m_prev_v = v;
        cur_v = v;
    endtask

    task automatic idle(input int n);
        repeat (n) pix(0, cur_v, 0, 1'b0);
    endtask

    // Block of pixels row by row, then a bright pixel at V=0 that closes the frame.
    task automatic run_frame(input int h0, input int v0, input int w, input int ht,
                             input bit rnd, input int g);
        for (int r = 0; r < ht; r++)
            for (int c = 0; c < w; c++)
                pix(h0 + c, v0 + r, rnd ? int'($urandom_range(0, 200)) : g,
                    rnd ? ($urandom_range(0, 7) != 0) : 1'b1);
        pix(0, 0, 500, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        iRST = 1'b1; iDVAL = 1'b0; iV_Cont = '0; iH_Cont = '0;
        sb_q.delete();
        hold_x0 = 0; hold_x1 = 0; hold_y0 = 0; hold_y1 = 0;
        m_cnt = 0; m_sx = 0; m_sy = 0; m_prev_v = 0; cur_v = 0;
        @(posedge clk);
        #1;
        iRST = 1'b0;
        @(negedge clk);
        check("rst_x0", oBOX_X0, 0);
        check("rst_x1", oBOX_X1, 0);
        check("rst_y0", oBOX_Y0, 0);
        check("rst_y1", oBOX_Y1, 0);
        check("rst_found", oFOUND, 0);
        check("rst_upd", oUPD, 0);
        check("rst_busy", oBUSY, 0);
    endtask

    always @(negedge clk) begin
        if (!iRST && oUPD === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_upd", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.found) begin
                    hold_x0 = lo_box(mon_e.cx);
                    hold_x1 = hi_box(mon_e.cx, H_MAX);
                    hold_y0 = lo_box(mon_e.cy);
                    hold_y1 = hi_box(mon_e.cy, V_MAX);
                end
                check("upd_edge", edge_cnt, mon_e.exp_edge);
                check("found", oFOUND, mon_e.found);
                check("box_x0", oBOX_X0, hold_x0);
                check("box_x1", oBOX_X1, hold_x1);
                check("box_y0", oBOX_Y0, hold_y0);
                check("box_y1", oBOX_Y1, hold_y1);
                check("busy_at_upd", oBUSY, 0);
            end
        end
    end

    initial begin
        int waited;
        int w, ht;
        do_reset();

        // centred 10x10 block
        run_frame(500, 400, 10, 10, 1'b0, 20);
        idle(75);
        // 63 dark pixels: one short of a detection
        run_frame(100, 10, 9, 7, 1'b0, 20);
        idle(5);
        // corner block, clamped at 0 and V_MAX
        run_frame(0, 950, 10, 10, 1'b0, 20);
        idle(75);
        // gray equal to threshold is not dark; one above threshold is
        thresh_m = 100;
        run_frame(700, 300, 10, 10, 1'b0, 100);
        idle(5);
        thresh_m = 101;
        run_frame(700, 300, 10, 10, 1'b0, 100);
        idle(75);
        thresh_m = 100;
        // second frame end 20 cycles into DIV_X
        run_frame(600, 500, 10, 10, 1'b0, 20);
        run_frame(300, 10, 19, 1, 1'b0, 20);
        idle(75);
        // second frame end inside DIV_Y with exactly MIN_PIX dark pixels, X1 clamped
        run_frame(200, 100, 10, 10, 1'b0, 20);
        run_frame(1270, 900, 8, 8, 1'b0, 20);
        idle(75);
        // tracking disabled
        en_m = 1'b0;
        run_frame(500, 400, 10, 10, 1'b0, 20);
        idle(5);
        en_m = 1'b1;
        // reset in the middle of DIV_Y
        run_frame(400, 300, 10, 10, 1'b0, 20);
        idle(40);
        @(negedge clk);
        check("busy_in_div", oBUSY, 1);
        do_reset();
        idle(100);
        run_frame(800, 600, 9, 9, 1'b0, 20);
        idle(75);
        // randomized frames
        repeat (12) begin
            w  = $urandom_range(3, 12);
            ht = $urandom_range(3, 12);
            run_frame($urandom_range(0, 1280 - w), $urandom_range(1, 960 - ht), w, ht, 1'b1, 0);
            idle(75);
        end

        waited = 0;
        while (sb_q.size() > 0 && waited < 500) begin
            idle(1);
            waited++;
        end
        check("drain", sb_q.size(), 0);
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
